sat_sub_accumulator: RTL

Streaming signed saturating subtract-accumulator for the datapath's saturating arithmetic group. It performs the inverse operation of the saturating adder: each accepted operand is subtracted from a running accumulator. Results clamp to the signed maximum/minimum instead of wrapping. Operands arrive on a valid/ready input channel, and each result leaves on a registered valid/ready output channel, one result per accepted operand.

---
 rtl/sat_sub_accumulator.sv | 130 +++++++++++++
 1 files changed

// File: rtl/sat_sub_accumulator.sv
// Streaming signed saturating subtract-accumulator.
// Each accepted operand either reloads the accumulator or is subtracted from it.
// Overflow clamps to the signed extremes instead of wrapping.
// The result leaves through a single registered valid/ready output stage.
module sat_sub_accumulator #(
  parameter int WIDTH     = 32,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 in_load,
  input  logic [WIDTH-1:0]     in_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WIDTH-1:0]     out_data,
  output logic                 out_sat,
  output logic                 sat_sticky,
  output logic [CNT_WIDTH-1:0] sat_count
);

  localparam logic signed [WIDTH-1:0] P_MAX   = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic signed [WIDTH-1:0] N_MAX   = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [CNT_WIDTH-1:0]    CNT_MAX = '1;

  typedef struct packed {
    logic                    sat;
    logic signed [WIDTH-1:0] val;
  } sub_t;

  // Overflow is detected from sign bits alone: it can only occur when the
  // operands differ in sign and the wrapped result takes the subtrahend's sign.
  function automatic sub_t sat_sub(input logic signed [WIDTH-1:0] a,
                                   input logic signed [WIDTH-1:0] b);
    sub_t                    r;
    logic signed [WIDTH-1:0] raw;
    raw   = a - b;
    r.sat = 1'b0;
    r.val = raw;
    if (!a[WIDTH-1] && b[WIDTH-1] && raw[WIDTH-1]) begin
      r.sat = 1'b1;
      r.val = P_MAX;
    end else if (a[WIDTH-1] && !b[WIDTH-1] && !raw[WIDTH-1]) begin
      r.sat = 1'b1;
      r.val = N_MAX;
    end
    return r;
  endfunction

  // Event counter that sticks at all-ones rather than wrapping.
  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] c);
    return (c == CNT_MAX) ? c : c + CNT_WIDTH'(1);
  endfunction

  logic signed [WIDTH-1:0] operand_p0;
  sub_t                    sub_p0;
  logic signed [WIDTH-1:0] nxt_val_p0;
  logic                    nxt_sat_p0;
  logic                    fire_p0;

  // The accumulator doubles as the output data register: out_data always
  // shows the accumulator value produced by the most recent accepted operand.
  logic signed [WIDTH-1:0] acc_p1;
  logic                    sat_p1;
  logic                    vld_p1;
  logic                    sticky_p1;
  logic [CNT_WIDTH-1:0]    count_p1;

  // Stage 0: operand decode and saturating subtract
  assign operand_p0 = in_data;
  assign sub_p0     = sat_sub(acc_p1, operand_p0);
  assign nxt_val_p0 = in_load ? operand_p0 : sub_p0.val;
  assign nxt_sat_p0 = !in_load && sub_p0.sat;

  // The output slot can take a new result when empty or being drained now.
  assign in_ready = !vld_p1 || out_ready;
  assign fire_p0  = in_valid && in_ready;

  // Stage 1: accumulator / result register, updated only on an accepted operand
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_p1 <= '0;
      sat_p1 <= 1'b0;
    end else if (fire_p0) begin
      acc_p1 <= nxt_val_p0;
      sat_p1 <= nxt_sat_p0;
    end
  end

  // Output valid: set on accept, cleared when consumed with nothing new behind it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1 <= 1'b0;
    end else if (fire_p0) begin
      vld_p1 <= 1'b1;
    end else if (out_ready) begin
      vld_p1 <= 1'b0;
    end
  end

  // Sticky clamp flag: a load starts a fresh run, any clamp marks it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sticky_p1 <= 1'b0;
    end else if (fire_p0) begin
      if (in_load) begin
        sticky_p1 <= 1'b0;
      end else if (nxt_sat_p0) begin
        sticky_p1 <= 1'b1;
      end
    end
  end

  // Clamp event counter; loads do not clear it, only reset does
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_p1 <= '0;
    end else if (fire_p0 && nxt_sat_p0) begin
      count_p1 <= sat_inc(count_p1);
    end
  end

  assign out_valid  = vld_p1;
  assign out_data   = acc_p1;
  assign out_sat    = sat_p1;
  assign sat_sticky = sticky_p1;
  assign sat_count  = count_p1;

endmodule
